// File: rtl/player_ctrl_pkg.sv
// Shared types and constants for the player movement scheduler:
// FSM state encoding, arbitration grant encoding and the default tick divider.
package player_ctrl_pkg;

    // 60 Hz movement tick from a 50 MHz clock.
    localparam int TICK_DIV_DEFAULT = 833_333;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        STEP,
        WAIT,
        CHECK,
        COMMIT
    } state_t;

    typedef enum logic {
        GRANT_ROT,
        GRANT_TRANS
    } grant_t;

endpackage

// File: rtl/player_tick_gen.sv
// Movement tick divider. Raises tick_pending on each counter wrap and holds it
// until the scheduler consumes it; wraps arriving while it is set are dropped.
module player_tick_gen
    import player_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    output logic tick_pending
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] count_q;
    logic          wrap;

    assign wrap = (count_q == CW'(TICK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q      <= '0;
            tick_pending <= 1'b0;
        end else begin
            count_q <= wrap ? '0 : count_q + CW'(1);
            // Clear wins: it only happens while a tick is already pending, so a coincident wrap is dropped.
            if (clear) begin
                tick_pending <= 1'b0;
            end else if (wrap) begin
                tick_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_move_scheduler.sv
// Turns held-key levels into rate-limited, one-at-a-time step strobes, gates
// translations through a wall check and commits only inside vertical blanking.
module player_move_scheduler
    import player_ctrl_pkg::*;
#(
    parameter int TICK_DIV      = TICK_DIV_DEFAULT,
    parameter int UPDATE_LAT    = 1,
    parameter int CHECK_TIMEOUT = 15
) (
    input  logic clock,
    input  logic resetn,
    input  logic forward,
    input  logic backward,
    input  logic rotate,
    input  logic vblank,
    output logic step_fwd,
    output logic step_back,
    output logic step_rot,
    output logic chk_req,
    input  logic chk_ack,
    input  logic chk_blocked,
    output logic commit,
    output logic blocked,
    output logic busy
);

    localparam int              TW           = $clog2(CHECK_TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(CHECK_TIMEOUT - 1);
    localparam logic [3:0]      WAIT_LOAD    = 4'(UPDATE_LAT);

    state_t        state_q, state_d;
    grant_t        last_grant_q, grant_d;
    logic          dir_fwd_q;
    logic [3:0]    wait_cnt_q;
    logic [TW-1:0] timeout_q;
    logic          blocked_q, blocked_d;
    logic          tick_pending;
    logic          tick_clear;
    logic          trans_req;

    player_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock        (clock),
        .resetn       (resetn),
        .clear        (tick_clear),
        .tick_pending (tick_pending)
    );

    // Both translation keys held cancel each other out.
    assign trans_req = forward ^ backward;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        grant_d    = last_grant_q;
        tick_clear = 1'b0;
        blocked_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick_pending && vblank) begin
                    state_d    = ARB;
                    tick_clear = 1'b1;
                end
            end
            ARB: begin
                if (rotate && trans_req) begin
                    grant_d = (last_grant_q == GRANT_TRANS) ? GRANT_ROT : GRANT_TRANS;
                    state_d = STEP;
                end else if (rotate) begin
                    grant_d = GRANT_ROT;
                    state_d = STEP;
                end else if (trans_req) begin
                    grant_d = GRANT_TRANS;
                    state_d = STEP;
                end else begin
                    state_d = IDLE;
                end
            end
            STEP: state_d = WAIT;
            WAIT: begin
                // A load of 0 or 1 both leave after a single WAIT cycle.
                if (wait_cnt_q <= 4'd1) begin
                    state_d = (last_grant_q == GRANT_ROT) ? COMMIT : CHECK;
                end
            end
            CHECK: begin
                if (chk_ack) begin
                    if (chk_blocked) begin
                        blocked_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = COMMIT;
                    end
                end else if (timeout_q == TIMEOUT_LAST) begin
                    blocked_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_TRANS;
            dir_fwd_q    <= 1'b0;
            wait_cnt_q   <= '0;
            timeout_q    <= '0;
            blocked_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= grant_d;
            blocked_q    <= blocked_d;
            if (state_q == ARB) begin
                dir_fwd_q <= forward;
            end
            if (state_q == STEP) begin
                wait_cnt_q <= WAIT_LOAD;
            end else if (state_q == WAIT && wait_cnt_q != 4'd0) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end
            timeout_q <= (state_q == CHECK) ? timeout_q + TW'(1) : '0;
        end
    end

    // Outputs decode registered state only, so reset silences them immediately.
    assign step_rot  = (state_q == STEP) && (last_grant_q == GRANT_ROT);
    assign step_fwd  = (state_q == STEP) && (last_grant_q == GRANT_TRANS) && dir_fwd_q;
    assign step_back = (state_q == STEP) && (last_grant_q == GRANT_TRANS) && !dir_fwd_q;
    assign chk_req   = (state_q == CHECK);
    assign commit    = (state_q == COMMIT);
    assign blocked   = blocked_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_player_move_scheduler.sv
// Bench for player_move_scheduler: arbitration table, directed timing sequences
// and a randomized run compared cycle by cycle against a sequence-timeline model.
module tb_player_move_scheduler;

    localparam int TDIV  = 10;
    localparam int ULAT  = 1;
    localparam int TOUT  = 4;
    localparam int NRAND = 2000;
    localparam int NMAX  = NRAND + 64;

    // Bit positions in the observed output vector.
    localparam int B_FWD  = 6;
    localparam int B_BACK = 5;
    localparam int B_ROT  = 4;
    localparam int B_REQ  = 3;
    localparam int B_COM  = 2;
    localparam int B_BLK  = 1;
    localparam int B_BUSY = 0;

    typedef struct packed {
        logic fwd;
        logic back;
        logic rot;
        logic vblank;
        logic ack;
        logic blk;
    } stim_t;

    typedef struct {
        logic       fwd;
        logic       back;
        logic       rot;
        logic [2:0] exp_step;   // {fwd, back, rot}
        int         exp_commit;
    } vec_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic forward = 1'b0, backward = 1'b0, rotate = 1'b0, vblank = 1'b0;
    logic chk_ack = 1'b0, chk_blocked = 1'b0;
    logic step_fwd, step_back, step_rot, chk_req, commit, blocked, busy;

    stim_t      stim  [NMAX];
    logic [6:0] obs   [NMAX];
    logic [6:0] exp_v [NMAX];
    vec_t       tbl   [12];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    player_move_scheduler #(
        .TICK_DIV      (TDIV),
        .UPDATE_LAT    (ULAT),
        .CHECK_TIMEOUT (TOUT)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .forward     (forward),
        .backward    (backward),
        .rotate      (rotate),
        .vblank      (vblank),
        .step_fwd    (step_fwd),
        .step_back   (step_back),
        .step_rot    (step_rot),
        .chk_req     (chk_req),
        .chk_ack     (chk_ack),
        .chk_blocked (chk_blocked),
        .commit      (commit),
        .blocked     (blocked),
        .busy        (busy)
    );

    function automatic logic [6:0] outs();
        return {step_fwd, step_back, step_rot, chk_req, commit, blocked, busy};
    endfunction

    function automatic logic signed [31:0] z(input logic [6:0] v);
        return {25'b0, v};
    endfunction

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input stim_t s);
        forward     = s.fwd;
        backward    = s.back;
        rotate      = s.rot;
        vblank      = s.vblank;
        chk_ack     = s.ack;
        chk_blocked = s.blk;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NMAX; i++) begin
            stim[i]  = '0;
            obs[i]   = '0;
            exp_v[i] = '0;
        end
    endtask

    // Leaves the bench at the negedge where resetn rises: that is cycle 0.
    task automatic do_reset();
        resetn = 1'b0;
        drive('0);
        repeat (3) @(negedge clock);
        check("reset_outputs", z(outs()), 0);
        resetn = 1'b1;
    endtask

    // Cycle c: sample outputs mid-cycle, then drive the inputs seen at the closing edge.
    task automatic run_capture(input int n);
        for (int c = 0; c < n; c++) begin
            obs[c] = outs();
            drive(stim[c]);
            @(negedge clock);
        end
    endtask

    function automatic int count_bit(input int b, input int lo, input int hi);
        int n;
        n = 0;
        for (int c = lo; c <= hi; c++) begin
            if (obs[c][b]) n++;
        end
        return n;
    endfunction

    function automatic int first_bit(input int b, input int lo, input int hi);
        for (int c = lo; c <= hi; c++) begin
            if (obs[c][b]) return c;
        end
        return -1;
    endfunction

    // Timeline of one sequence whose arbitration cycle is a; fills the expected
    // outputs and the wall-check response, returns the first idle cycle.
    task automatic plan_seq(input int a, inout bit rot_last, output int idle_at);
        bit r, t, take_rot, blk;
        int s, e, d, done;
        r = stim[a].rot;
        t = stim[a].fwd ^ stim[a].back;
        if (!r && !t) begin
            done = a + 1;
        end else begin
            take_rot = r && (!t || !rot_last);
            rot_last = take_rot;
            s = a + 1;
            if (take_rot)          exp_v[s][B_ROT]  = 1'b1;
            else if (stim[a].fwd)  exp_v[s][B_FWD]  = 1'b1;
            else                   exp_v[s][B_BACK] = 1'b1;
            e = s + ((ULAT > 1) ? ULAT : 1) + 1;
            if (take_rot) begin
                exp_v[e][B_COM] = 1'b1;
                done = e + 1;
            end else begin
                for (int i = 0; i < TOUT; i++) stim[e + i].ack = 1'b0;
                d = $urandom_range(TOUT, 0);
                if (d < TOUT) begin
                    blk = 1'($urandom_range(1, 0));
                    stim[e + d].ack = 1'b1;
                    stim[e + d].blk = blk;
                    for (int i = 0; i <= d; i++) exp_v[e + i][B_REQ] = 1'b1;
                    if (blk) begin
                        exp_v[e + d + 1][B_BLK] = 1'b1;
                        done = e + d + 1;
                    end else begin
                        exp_v[e + d + 1][B_COM] = 1'b1;
                        done = e + d + 2;
                    end
                end else begin
                    for (int i = 0; i < TOUT; i++) exp_v[e + i][B_REQ] = 1'b1;
                    exp_v[e + TOUT][B_BLK] = 1'b1;
                    done = e + TOUT;
                end
            end
        end
        for (int i = a; i < done; i++) exp_v[i][B_BUSY] = 1'b1;
        idle_at = done;
    endtask

    task automatic plan_random();
        bit pend, rot_last, leave;
        int idle_at;
        pend     = 1'b0;
        rot_last = 1'b0;
        idle_at  = 0;
        for (int c = 0; c < NRAND; c++) begin
            leave = 1'b0;
            if (c >= idle_at && pend && stim[c].vblank) begin
                leave = 1'b1;
                plan_seq(c + 1, rot_last, idle_at);
            end
            if (leave)                      pend = 1'b0;
            else if (c % TDIV == TDIV - 1)  pend = 1'b1;
        end
    endtask

    task automatic gen_random();
        stim_t cur;
        cur = '0;
        cur.vblank = 1'b1;
        for (int c = 0; c < NRAND; c++) begin
            if ($urandom_range(3, 0) == 0) begin
                cur.fwd  = 1'($urandom_range(1, 0));
                cur.back = 1'($urandom_range(1, 0));
                cur.rot  = 1'($urandom_range(1, 0));
            end
            if ($urandom_range(7, 0) == 0) cur.vblank = ~cur.vblank;
            cur.ack = ($urandom_range(3, 0) == 0);
            cur.blk = 1'($urandom_range(1, 0));
            stim[c] = cur;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] seen;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 3'b000, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 3'b001, 1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'b100, 1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 3'b010, 1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'b000, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 3'b001, 1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 3'b100, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 3'b001, 1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 3'b100, 1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 3'b001, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 3'b010, 1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 3'b001, 1};

        // Arbitration table: one tick window of 10 cycles per entry, immediate clear ack.
        clear_stim();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < TDIV; j++) begin
                stim[k * TDIV + j] = {tbl[k].fwd, tbl[k].back, tbl[k].rot, 1'b1, 1'b1, 1'b0};
            end
        end
        run_capture(12 * TDIV);
        for (int k = 0; k < 12; k++) begin
            seen = {count_bit(B_FWD,  k * TDIV, k * TDIV + TDIV - 1) > 0,
                    count_bit(B_BACK, k * TDIV, k * TDIV + TDIV - 1) > 0,
                    count_bit(B_ROT,  k * TDIV, k * TDIV + TDIV - 1) > 0};
            check($sformatf("tbl%0d_step", k), {29'b0, seen}, {29'b0, tbl[k].exp_step});
            check($sformatf("tbl%0d_commit", k),
                  count_bit(B_COM, k * TDIV, k * TDIV + TDIV - 1), tbl[k].exp_commit);
        end

        // Rotate held: strobe at 12, 22, 32, each commit two cycles later.
        clear_stim();
        do_reset();
        for (int c = 0; c < 40; c++) stim[c] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        run_capture(40);
        check("rot_first_strobe", first_bit(B_ROT, 0, 39), 12);
        check("rot_strobe_count", count_bit(B_ROT, 0, 39), 3);
        check("rot_commit_count", count_bit(B_COM, 0, 39), 3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rot_commit_at_%0d", 14 + 10 * k), count_bit(B_COM, 14 + 10 * k, 14 + 10 * k), 1);
        end
        check("rot_no_trans", count_bit(B_FWD, 0, 39) + count_bit(B_BACK, 0, 39), 0);
        check("rot_busy_10", count_bit(B_BUSY, 10, 10), 0);
        check("rot_busy_11_14", count_bit(B_BUSY, 11, 14), 4);
        check("rot_busy_15", count_bit(B_BUSY, 15, 15), 0);

        // Forward held, clear ack two cycles after chk_req rises.
        clear_stim();
        do_reset();
        for (int c = 0; c < 20; c++) stim[c] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        stim[16].ack = 1'b1;
        run_capture(20);
        check("fwd_strobe_at", first_bit(B_FWD, 0, 19), 12);
        check("fwd_strobe_count", count_bit(B_FWD, 0, 19), 1);
        check("fwd_req_rise", first_bit(B_REQ, 0, 19), 14);
        check("fwd_req_len", count_bit(B_REQ, 0, 19), 3);
        check("fwd_commit_at", first_bit(B_COM, 0, 19), 17);
        check("fwd_commit_count", count_bit(B_COM, 0, 19), 1);
        check("fwd_blocked_count", count_bit(B_BLK, 0, 19), 0);

        // Forward held, no ack inside CHECK (stray acks before it): timeout.
        clear_stim();
        do_reset();
        for (int c = 0; c < 20; c++) stim[c] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int c = 11; c <= 13; c++) stim[c].ack = 1'b1;
        run_capture(20);
        check("to_req_rise", first_bit(B_REQ, 0, 19), 14);
        check("to_req_len", count_bit(B_REQ, 0, 19), TOUT);
        check("to_blocked_at", first_bit(B_BLK, 0, 19), 18);
        check("to_blocked_count", count_bit(B_BLK, 0, 19), 1);
        check("to_commit_count", count_bit(B_COM, 0, 19), 0);
        check("to_busy_17", count_bit(B_BUSY, 17, 17), 1);
        check("to_busy_18", count_bit(B_BUSY, 18, 18), 0);

        // vblank low for 25 cycles: two wraps collapse into one sequence.
        clear_stim();
        do_reset();
        for (int c = 0; c < 31; c++) stim[c] = {1'b0, 1'b0, 1'b1, (c >= 25), 1'b0, 1'b0};
        run_capture(31);
        check("vb_strobe_count", count_bit(B_ROT, 0, 30), 1);
        check("vb_strobe_at", first_bit(B_ROT, 0, 30), 27);

        // Reset asserted while in WAIT.
        clear_stim();
        do_reset();
        for (int c = 0; c < 13; c++) stim[c] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        run_capture(13);
        check("rst_pre_strobe", first_bit(B_ROT, 0, 12), 12);
        check("rst_pre_wait", z(outs()), 1);
        #1 resetn = 1'b0;
        #1 check("rst_mid_wait", z(outs()), 0);
        clear_stim();
        do_reset();
        for (int c = 0; c < 16; c++) stim[c] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        run_capture(16);
        check("rst_no_commit", count_bit(B_COM, 0, 11), 0);
        check("rst_no_strobe", count_bit(B_ROT, 0, 11), 0);
        check("rst_resume_commit", first_bit(B_COM, 0, 15), 14);

        // Randomized run against the timeline model.
        clear_stim();
        gen_random();
        plan_random();
        do_reset();
        run_capture(NRAND);
        for (int c = 0; c < NRAND; c++) begin
            check($sformatf("rand_c%0d", c), z(obs[c]), z(exp_v[c]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
